hc_loopback_engine: RTL
=======================

Name: hc_loopback_engine

Overview:
- Parametrised copy engine. On start, it reads LEN cache lines from source buffer SRC_BUF through the read channel and writes each line unchanged to the same offset in DST_BUF.
- Supersedes the fixed-size, single-buffer, read-only loopback. Adds runtime length, selectable buffers, write-back, a credit-limited outstanding window and out-of-order response handling.
- Sits between the top-level job control and the buffer request/response channels.

Parameters:
- DATA_W, 512: cache-line payload width in bits.
- IDX_W, 32: cache-line offset width; also the width of len.
- BUF_ID_W, 4: buffer identifier width.
- MAX_OUTSTANDING, 16: maximum reads in flight plus lines held in the internal FIFO. Must be a power of 2, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  level-sampled job start.
- len  in  IDX_W  number of lines to copy; sampled with start.
- src_buf  in  BUF_ID_W  source buffer; sampled with start.
- dst_buf  in  BUF_ID_W  destination buffer; sampled with start.
- rd_req_valid  out  1  read request valid.
- rd_req_ready  in  1  read channel not full.
- rd_req_buf  out  BUF_ID_W  read buffer id.
- rd_req_idx  out  IDX_W  read line offset.
- rd_rsp_valid  in  1  read response valid; cannot be back-pressured.
- rd_rsp_idx  in  IDX_W  offset of the returned line.
- rd_rsp_data  in  DATA_W  returned line.
- wr_req_valid  out  1  write request valid.
- wr_req_ready  in  1  write channel not full.
- wr_req_buf  out  BUF_ID_W  write buffer id.
- wr_req_idx  out  IDX_W  write line offset.
- wr_req_data  out  DATA_W  write line.
- wr_rsp_valid  in  1  one write completed.
- busy  out  1  job in progress.
- finish  out  1  job complete; level signal.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; FIFO empty.
- States and transitions:
  - IDLE → RUN when start=1. Latch len, src_buf, dst_buf.
  - IDLE → DONE when start=1 and len==0; finish=1 on the next cycle.
  - RUN → DRAIN when the issued count equals len.
  - DRAIN → DONE when the completed-write count equals len.
  - DONE holds finish=1. start=1 in DONE begins a new job, same rules as IDLE; finish drops in that cycle.
- start is ignored in RUN and DRAIN. busy=1 in RUN and DRAIN only.
- Read issue:
  - A request transfers when rd_req_valid && rd_req_ready.
  - Offsets are issued in order 0..len-1. rd_req_buf = latched src_buf.
  - rd_req_valid=1 only if credits < MAX_OUTSTANDING.
  - credits = reads in flight + FIFO occupancy. +1 on a read transfer; -1 on a write transfer.
  - A read transfer and a write transfer in the same cycle leave credits unchanged.
- Read responses:
  - Any order is accepted. Every rd_rsp_valid pushes {idx, data} into the FIFO.
  - The credit rule guarantees the FIFO never overflows. An overflow is a design error; covered by an assertion.
- Write:
  - The FIFO head drives wr_req_*. wr_req_buf = latched dst_buf. wr_req_idx = response idx.
  - wr_req_valid = FIFO not empty. Pop on wr_req_valid && wr_req_ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (pop frees the slot).
  - Write requests may be presented in any order; the destination offset is always the returned idx.
- Completion: count wr_rsp_valid pulses; compare against latched len.
- Latency:
  - First rd_req_valid one cycle after start is sampled.
  - A response reaches wr_req_valid one cycle after rd_rsp_valid (registered FIFO).
- Counters are IDX_W wide; len = 2^IDX_W-1 must not wrap.
- Reset mid-job: all state clears immediately; any later in-flight responses are ignored, since no job is active and responses are dropped in IDLE.

Optional Feature:
- HC_LPBK_PERF_EN defined:
  - Adds output perf_cycles (32 bits).
  - Cleared on job start; increments every cycle in RUN and DRAIN; holds its value in DONE.
  - Saturates at 0xFFFFFFFF.
- HC_LPBK_PERF_EN undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Basic copy:
  - Stimulus: len=100, src=1, dst=2, rd_req_ready=1, wr_req_ready=1, in-order responses with latency 5.
  - Required: 100 writes to buffer 2 at idx 0..99 with matching data; finish=1; busy=0.
- Zero length:
  - Stimulus: len=0.
  - Required: no rd/wr requests; finish=1 one cycle after start.
- Credit limit:
  - Stimulus: MAX_OUTSTANDING=16, responses withheld.
  - Required: exactly 16 read requests, then rd_req_valid=0 until responses return.
- Out-of-order and back-pressure:
  - Stimulus: len=32, responses shuffled, wr_req_ready toggling 50%.
  - Required: each idx written once with correct data; no FIFO overflow.
- Reset mid-job:
  - Stimulus: reset at request 10 of len=50, then start len=8.
  - Required: outputs 0 during reset; second job completes with exactly 8 writes.
- Perf counter (with HC_LPBK_PERF_EN):
  - Stimulus: len=4, fixed latency.
  - Required: perf_cycles equals the RUN+DRAIN cycle count, then stable in DONE.

Source files
------------

// File: rtl/hc_loopback_engine_if.sv
// rtl/hc_loopback_engine_if.sv - read/write buffer channel bundle for the loopback copy engine
interface hc_loopback_engine_if #(
  parameter int DATA_W   = 512,
  parameter int IDX_W    = 32,
  parameter int BUF_ID_W = 4
);
  logic                rd_req_valid;
  logic                rd_req_ready;
  logic [BUF_ID_W-1:0] rd_req_buf;
  logic [IDX_W-1:0]    rd_req_idx;
  logic                rd_rsp_valid;
  logic [IDX_W-1:0]    rd_rsp_idx;
  logic [DATA_W-1:0]   rd_rsp_data;
  logic                wr_req_valid;
  logic                wr_req_ready;
  logic [BUF_ID_W-1:0] wr_req_buf;
  logic [IDX_W-1:0]    wr_req_idx;
  logic [DATA_W-1:0]   wr_req_data;
  logic                wr_rsp_valid;

  modport master (
    output rd_req_valid, rd_req_buf, rd_req_idx,
    input  rd_req_ready,
    input  rd_rsp_valid, rd_rsp_idx, rd_rsp_data,
    output wr_req_valid, wr_req_buf, wr_req_idx, wr_req_data,
    input  wr_req_ready,
    input  wr_rsp_valid
  );

  modport slave (
    input  rd_req_valid, rd_req_buf, rd_req_idx,
    output rd_req_ready,
    output rd_rsp_valid, rd_rsp_idx, rd_rsp_data,
    input  wr_req_valid, wr_req_buf, wr_req_idx, wr_req_data,
    output wr_req_ready,
    output wr_rsp_valid
  );
endinterface

// File: rtl/hc_loopback_engine.sv
// rtl/hc_loopback_engine.sv - credit-limited buffer-to-buffer line copy engine
// Optional HC_LPBK_PERF_EN adds the perf_cycles job cycle counter.
module hc_loopback_engine #(
  parameter int DATA_W          = 512,
  parameter int IDX_W           = 32,
  parameter int BUF_ID_W        = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IDX_W-1:0]    len,
  input  logic [BUF_ID_W-1:0] src_buf,
  input  logic [BUF_ID_W-1:0] dst_buf,
  hc_loopback_engine_if.master bus,
  output logic                busy,
  output logic                finish
`ifdef HC_LPBK_PERF_EN
  ,
  output logic [31:0]         perf_cycles
`endif
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0]        len_q, issued, completed;
  logic [BUF_ID_W-1:0]     src_q, dst_q;
  logic [CNT_W-1:0]        credits, fifo_count;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [IDX_W+DATA_W-1:0] fifo_mem [MAX_OUTSTANDING];

  logic job_start, active, rd_fire, wr_fire, push, fifo_empty, fifo_full;

  assign job_start  = start && (state == IDLE || state == DONE);
  assign active     = (state == RUN) || (state == DRAIN);
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CREDIT_MAX);
  assign rd_fire    = bus.rd_req_valid && bus.rd_req_ready;
  assign wr_fire    = bus.wr_req_valid && bus.wr_req_ready;
  // Responses outside a job are stale (e.g. after a reset) and are dropped.
  assign push       = active && bus.rd_rsp_valid;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: a zero-length job goes straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (len == '0) ? DONE : RUN;
      RUN:        if (issued == len_q) state_nxt = DRAIN;
      DRAIN:      if (completed == len_q) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs: reads gated by the credit window, writes driven from the FIFO head.
  always_comb begin
    busy             = active;
    finish           = (state == DONE) && !start;
    bus.rd_req_valid = (state == RUN) && (issued != len_q) && (credits < CREDIT_MAX);
    bus.rd_req_buf   = src_q;
    bus.rd_req_idx   = issued;
    bus.wr_req_valid = !fifo_empty;
    bus.wr_req_buf   = dst_q;
    {bus.wr_req_idx, bus.wr_req_data} = fifo_empty ? '0 : fifo_mem[rd_ptr];
  end

  // Job parameters and issue/completion counters, restarted on each job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      issued    <= '0;
      completed <= '0;
    end else if (job_start) begin
      len_q     <= len;
      src_q     <= src_buf;
      dst_q     <= dst_buf;
      issued    <= '0;
      completed <= '0;
    end else begin
      if (rd_fire) issued <= issued + 1'b1;
      if (active && bus.wr_rsp_valid) completed <= completed + 1'b1;
    end
  end

  // Credits track reads in flight plus lines parked in the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) credits <= '0;
    else begin
      case ({rd_fire, wr_fire})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop both proceed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (wr_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({push, wr_fire})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.rd_rsp_idx, bus.rd_rsp_data};
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full && !wr_fire));

`ifdef HC_LPBK_PERF_EN
  // Job cycle counter: cleared at start, saturating, frozen outside RUN/DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          perf_cycles <= '0;
    else if (job_start)                 perf_cycles <= '0;
    else if (active && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
  end
`endif
endmodule
